lsu_handshake: RTL and testbench
================================

Name: lsu_handshake

Overview:
- Parametrised load/store unit placed between the core datapath and data memory.
- Replaces the fixed 12-bit, always-ready, single-cycle memory path with a valid/ready request interface and a req/gnt/rvalid memory interface.
- Supports configurable address and data widths, byte-lane alignment, sign/zero extension of loads, misalignment detection and a response timeout.
- The core stalls while req_ready_o is low or a response is outstanding.

Parameters:
- ADDR_WIDTH, 12, byte address width.
- DATA_WIDTH, 32, memory word width; legal values are 32 and 64. NB = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 0, cycles allowed in REQ+WAIT before a timeout error; 0 disables the timeout.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  request accepted when valid&&ready.
- req_we_i  in  1  1=store, 0=load.
- req_funct3_i  in  3  RISC-V size/sign field: 000 B, 001 H, 010 W, 011 D (64 only), 100 BU, 101 HU, 110 WU (64 only).
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  store data, LSB-justified.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err_o  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_we_o  out  1  memory write.
- mem_be_o  out  NB  byte enables.
- mem_addr_o  out  ADDR_WIDTH  word-aligned address; low log2(NB) bits are 0.
- mem_wdata_o  out  DATA_WIDTH  lane-aligned store data.
- mem_rvalid_i  in  1  read data valid, or write acknowledge.
- mem_rdata_i  in  DATA_WIDTH  read data.

Behaviour:
- Reset (async, any state): state=IDLE, timeout counter=0, all outputs 0 except req_ready_o=1.
- States: IDLE, REQ, WAIT, RESP, DRAIN.
- req_ready_o=1 only in IDLE.
- IDLE:
  - On accept, register we, funct3, byte offset, aligned address, BE and aligned wdata.
  - Illegal funct3 (store with funct3[2]=1; 011 or 110 with DATA_WIDTH=32; 111 always) -> RESP, err 11, no memory access.
  - Misaligned access (H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0) -> RESP, err 01, no memory access.
  - Otherwise -> REQ.
- REQ:
  - mem_req_o=1, and address/we/be/wdata are held stable until mem_gnt_i.
  - On gnt -> WAIT.
- WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i, capture extended data (zero for stores) -> RESP, err 00.
  - mem_rvalid_i is ignored in every state except WAIT and DRAIN.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, with rdata/err registered.
  - Next state is IDLE. There is no back-pressure on the response.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter clears on accept and increments each cycle in REQ or WAIT.
  - When the counter reaches TIMEOUT_CYCLES with no gnt (in REQ) or no rvalid (in WAIT) that cycle, set err 10 and rdata 0.
  - From REQ -> RESP, deasserting mem_req_o.
  - From WAIT -> DRAIN.
- DRAIN:
  - rsp_valid_o pulses once on entry (same cycle as RESP would).
  - The block then stays in DRAIN with req_ready_o=0 until mem_rvalid_i, which is discarded -> IDLE.
  - A gnt or rvalid arriving in the same cycle as the timeout wins over the timeout.
- Store alignment:
  - B: wdata byte replicated to all lanes, be = 1<<off.
  - H: halfword replicated, be = 2'b11<<off.
  - W: be = 4'hF<<off; word replicated on 64.
  - D: all ones.
- Load extraction:
  - Shift mem_rdata_i right by off*8.
  - Sign-extend B/H/W; zero-extend BU/HU/WU.
  - D passes through.
- Minimum latency, with gnt and rvalid each arriving on their first opportunity: accept at edge k -> REQ during k+1 -> WAIT during k+2 -> rsp_valid_o during cycle k+3.
- Error responses (illegal/misaligned): rsp_valid_o at k+1.

Decomposition:
- Package lsu_pkg holds:
  - state enum;
  - err codes ERR_OK/ERR_MISALIGN/ERR_TIMEOUT/ERR_ILLEGAL;
  - funct3 constants F3_B..F3_WU.
- Sub-module lsu_align is combinational: store lane replication, BE generation, misalign/illegal checks and load shift/extension, parametrised on DATA_WIDTH.
- The top module holds the FSM, capture registers and timeout counter.

Test Plan:
- Load word, DATA_WIDTH=32: addr 0x104, funct3 010, gnt and rvalid immediate, mem_rdata=0xDEADBEEF -> mem_addr_o=0x104, be=F, rsp_rdata_o=0xDEADBEEF, err 00, rsp_valid_o 3 cycles after accept.
- LB then LBU at addr 0x103, mem_rdata=0x80112233 -> 0xFFFFFF80, then 0x00000080.
- Store byte 0xA5 at addr 0x002 with funct3 000 -> mem_be_o=0100, mem_wdata_o=0xA5A5A5A5, mem_we_o=1; response rdata 0, err 00.
- LH at addr 0x001 -> no mem_req_o, rsp_valid_o one cycle after accept, err 01. LD with DATA_WIDTH=32 -> err 11.
- Timeout with TIMEOUT_CYCLES=4:
  - gnt withheld -> mem_req_o drops, err 10, block returns to IDLE.
  - Separate run: gnt given but rvalid arrives 10 cycles later -> err 10 pulse, req_ready_o stays 0 until rvalid, then 1; late data is never reported.
- Stall and reset:
  - gnt delayed 5 cycles -> mem_addr/be/wdata stable throughout REQ.
  - rstn_i asserted in WAIT -> all outputs 0, req_ready_o=1 immediately; a following request completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWait,
      StResp,
      StDrain
   } lsu_state_e;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   // Access size in bytes; the sign bit funct3[2] does not affect the size.
   function automatic int unsigned f3_size_bytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 8;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication, byte enables, access checks
// and load shift/extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned NB = DATA_WIDTH / 8,
   localparam int unsigned OW = $clog2(NB)
) (
   input  logic                  req_we_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [OW-1:0]         req_off_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic [NB-1:0]         be_o,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic                  illegal_o,
   output logic                  misalign_o,
   input  logic [2:0]            rsp_funct3_i,
   input  logic [OW-1:0]         rsp_off_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic [DATA_WIDTH-1:0] ld_data_o
);

   int unsigned          req_sz;
   int unsigned          ld_w;
   logic                 ld_sgn;
   logic [DATA_WIDTH-1:0] ld_shifted;

   // Request side: legality, alignment, lane enables and replicated store data.
   always_comb begin
      req_sz     = f3_size_bytes(req_funct3_i);
      illegal_o  = (req_funct3_i == 3'b111) || (req_we_i && req_funct3_i[2]) ||
                   ((DATA_WIDTH == 32) && ((req_funct3_i == F3_D) || (req_funct3_i == F3_WU)));
      misalign_o = ((32'(req_off_i) & (req_sz - 32'd1)) != 32'd0);
      for (int unsigned i = 0; i < NB; i++) begin
         be_o[i] = (i >= 32'(req_off_i)) && (i < 32'(req_off_i) + req_sz);
         // Lane i takes byte (i mod size): the aligned copy lands on the enabled lanes.
         case (req_funct3_i[1:0])
            2'b00:   wdata_o[8*i +: 8] = req_wdata_i[7:0];
            2'b01:   wdata_o[8*i +: 8] = req_wdata_i[8*(i%2) +: 8];
            2'b10:   wdata_o[8*i +: 8] = req_wdata_i[8*(i%4) +: 8];
            default: wdata_o[8*i +: 8] = req_wdata_i[8*i +: 8];
         endcase
      end
   end

   // Response side: shift the addressed lanes down, then sign or zero extend.
   always_comb begin
      ld_shifted = mem_rdata_i >> {rsp_off_i, 3'b000};
      case (rsp_funct3_i[1:0])
         2'b00:   ld_w = 8;
         2'b01:   ld_w = 16;
         2'b10:   ld_w = 32;
         default: ld_w = DATA_WIDTH;
      endcase
      ld_sgn = 1'b0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         if (i == ld_w - 1) ld_sgn = ld_shifted[i] & ~rsp_funct3_i[2];
      end
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         ld_data_o[i] = (i < ld_w) ? ld_shifted[i] : ld_sgn;
      end
   end

endmodule

// File: rtl/lsu_handshake.sv
// Load/store unit: valid/ready core request in, req/gnt/rvalid memory port out.
module lsu_handshake
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 0,
   localparam int unsigned NB = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic [1:0]            rsp_err_o,
   output logic                  mem_req_o,
   input  logic                  mem_gnt_i,
   output logic                  mem_we_o,
   output logic [NB-1:0]         mem_be_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam int unsigned OW        = $clog2(NB);
   localparam bit          TimeoutEn = (TIMEOUT_CYCLES > 0);
   localparam int unsigned CntW      = TimeoutEn ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CntW-1:0] CntLast = TimeoutEn ? CntW'(TIMEOUT_CYCLES - 1) : '0;

   lsu_state_e state_q, state_d;

   logic                  we_q;
   logic [2:0]            funct3_q;
   logic [OW-1:0]         off_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [NB-1:0]         be_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]            rsp_err_q, rsp_err_d;

   logic                  accept;
   logic                  timeout_hit;
   logic [NB-1:0]         al_be;
   logic [DATA_WIDTH-1:0] al_wdata;
   logic                  al_illegal;
   logic                  al_misalign;
   logic [DATA_WIDTH-1:0] ld_data;

   assign accept = req_valid_i && (state_q == StIdle);
   // Fires on the TIMEOUT_CYCLES-th cycle spent in REQ+WAIT; gnt/rvalid take priority.
   assign timeout_hit = TimeoutEn && (cnt_q >= CntLast);

   lsu_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_align (
      .req_we_i     (req_we_i),
      .req_funct3_i (req_funct3_i),
      .req_off_i    (req_addr_i[OW-1:0]),
      .req_wdata_i  (req_wdata_i),
      .be_o         (al_be),
      .wdata_o      (al_wdata),
      .illegal_o    (al_illegal),
      .misalign_o   (al_misalign),
      .rsp_funct3_i (funct3_q),
      .rsp_off_i    (off_q),
      .mem_rdata_i  (mem_rdata_i),
      .ld_data_o    (ld_data)
   );

   // Capture the accepted request; held stable for the whole memory access.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         off_q    <= '0;
         addr_q   <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
      end else if (accept) begin
         we_q     <= req_we_i;
         funct3_q <= req_funct3_i;
         off_q    <= req_addr_i[OW-1:0];
         addr_q   <= {req_addr_i[ADDR_WIDTH-1:OW], {OW{1'b0}}};
         be_q     <= al_be;
         wdata_q  <= al_wdata;
      end
   end

   // State, timeout counter and registered response.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= ERR_OK;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Next state, counter and response contents.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_rdata_d = '0;
      rsp_err_d   = ERR_OK;
      case (state_q)
         StIdle: begin
            if (accept) begin
               cnt_d = '0;
               if (al_illegal) begin
                  state_d   = StResp;
                  rsp_err_d = ERR_ILLEGAL;
               end else if (al_misalign) begin
                  state_d   = StResp;
                  rsp_err_d = ERR_MISALIGN;
               end else begin
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            if (TimeoutEn) cnt_d = cnt_q + CntW'(1);
            if (mem_gnt_i) begin
               state_d = StWait;
            end else if (timeout_hit) begin
               state_d   = StResp;
               rsp_err_d = ERR_TIMEOUT;
            end
         end
         StWait: begin
            if (TimeoutEn) cnt_d = cnt_q + CntW'(1);
            if (mem_rvalid_i) begin
               state_d     = StResp;
               rsp_rdata_d = we_q ? '0 : ld_data;
            end else if (timeout_hit) begin
               // The memory still owes a response; absorb it in DRAIN.
               state_d   = StDrain;
               rsp_err_d = ERR_TIMEOUT;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         StDrain: begin
            if (mem_rvalid_i) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      rsp_valid_d = (state_d == StResp) || ((state_d == StDrain) && (state_q != StDrain));
   end

   // Output decode; memory-side fields are only driven while requesting.
   always_comb begin
      req_ready_o = (state_q == StIdle);
      mem_req_o   = (state_q == StReq);
      mem_we_o    = mem_req_o & we_q;
      mem_be_o    = mem_req_o ? be_q : '0;
      mem_addr_o  = mem_req_o ? addr_q : '0;
      mem_wdata_o = mem_req_o ? wdata_q : '0;
      rsp_valid_o = rsp_valid_q;
      rsp_rdata_o = rsp_rdata_q;
      rsp_err_o   = rsp_err_q;
   end

endmodule

// File: tb/tb_lsu_handshake.sv
// Directed bench: dut 0 has no timeout, dut 1 has TIMEOUT_CYCLES=4.
module tb_lsu_handshake;

   typedef struct {
      bit          sel;
      bit          we;
      logic [2:0]  f3;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrdata;
      int          gnt_dly;
      int          rv_dly;
      bit          exp_mreq;
      logic [11:0] exp_maddr;
      logic [3:0]  exp_be;
      logic [31:0] exp_mwdata;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_err;
      int          exp_lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        valid0 = 1'b0, valid1 = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [11:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   logic        o_ready [2];
   logic        o_rsp_valid [2];
   logic [31:0] o_rsp_rdata [2];
   logic [1:0]  o_rsp_err [2];
   logic        o_mem_req [2];
   logic        o_mem_we [2];
   logic [3:0]  o_mem_be [2];
   logic [11:0] o_mem_addr [2];
   logic [31:0] o_mem_wdata [2];

   int n_vec = 0;
   int n_err = 0;
   bit sel = 1'b0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   lsu_handshake #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)) dut0 (
      .clk_i(clk), .rstn_i(rstn), .req_valid_i(valid0), .req_ready_o(o_ready[0]),
      .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .rsp_valid_o(o_rsp_valid[0]), .rsp_rdata_o(o_rsp_rdata[0]),
      .rsp_err_o(o_rsp_err[0]), .mem_req_o(o_mem_req[0]), .mem_gnt_i(mem_gnt),
      .mem_we_o(o_mem_we[0]), .mem_be_o(o_mem_be[0]), .mem_addr_o(o_mem_addr[0]),
      .mem_wdata_o(o_mem_wdata[0]), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
   );

   lsu_handshake #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut1 (
      .clk_i(clk), .rstn_i(rstn), .req_valid_i(valid1), .req_ready_o(o_ready[1]),
      .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata), .rsp_valid_o(o_rsp_valid[1]), .rsp_rdata_o(o_rsp_rdata[1]),
      .rsp_err_o(o_rsp_err[1]), .mem_req_o(o_mem_req[1]), .mem_gnt_i(mem_gnt),
      .mem_we_o(o_mem_we[1]), .mem_be_o(o_mem_be[1]), .mem_addr_o(o_mem_addr[1]),
      .mem_wdata_o(o_mem_wdata[1]), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit s, bit we, logic [2:0] f3, logic [11:0] addr,
                               logic [31:0] wd, logic [31:0] mrd, int gd, int rd, bit mreq,
                               logic [11:0] maddr, logic [3:0] be, logic [31:0] mwd,
                               logic [31:0] rdat, logic [1:0] err, int lat);
      vec_t v;
      v.sel = s; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wd; v.mrdata = mrd;
      v.gnt_dly = gd; v.rv_dly = rd; v.exp_mreq = mreq; v.exp_maddr = maddr;
      v.exp_be = be; v.exp_mwdata = mwd; v.exp_rdata = rdat; v.exp_err = err;
      v.exp_lat = lat;
      return v;
   endfunction

   // Present one request at a negedge, then play memory with the given delays.
   task automatic drive_req(input bit s, input bit we, input logic [2:0] f3,
                            input logic [11:0] addr, input logic [31:0] wd);
      sel = s; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      if (s) valid1 = 1'b1; else valid0 = 1'b1;
      #1 chk("ready before accept", 64'(o_ready[sel]), 64'd1);
      @(posedge clk);
      @(negedge clk);
      valid0 = 1'b0; valid1 = 1'b0;
   endtask

   task automatic run_txn(input vec_t v);
      int  lat = 0;
      int  rq = 0;
      int  wt = 0;
      bit  seen = 1'b0;
      bit  granted = 1'b0;
      mem_rdata = v.mrdata;
      drive_req(v.sel, v.we, v.f3, v.addr, v.wdata);
      for (int c = 1; c <= 40; c++) begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         #1;
         if (o_rsp_valid[sel]) begin
            lat = c;
            break;
         end
         if (o_mem_req[sel]) begin
            seen = 1'b1;
            chk("mem_addr", 64'(o_mem_addr[sel]), 64'(v.exp_maddr));
            chk("mem_be", 64'(o_mem_be[sel]), 64'(v.exp_be));
            chk("mem_wdata", 64'(o_mem_wdata[sel]), 64'(v.exp_mwdata));
            chk("mem_we", 64'(o_mem_we[sel]), 64'(v.we));
            if (rq == v.gnt_dly) begin
               mem_gnt = 1'b1;
               granted = 1'b1;
            end
            rq++;
         end else if (granted) begin
            if (wt == v.rv_dly) mem_rvalid = 1'b1;
            wt++;
         end
         @(negedge clk);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("rsp latency", 64'(lat), 64'(v.exp_lat));
      chk("rsp_rdata", 64'(o_rsp_rdata[sel]), 64'(v.exp_rdata));
      chk("rsp_err", 64'(o_rsp_err[sel]), 64'(v.exp_err));
      chk("mem_req at rsp", 64'(o_mem_req[sel]), 64'd0);
      chk("mem access seen", 64'(seen), 64'(v.exp_mreq));
      @(negedge clk);
      #1;
      chk("rsp one-cycle", 64'(o_rsp_valid[sel]), 64'd0);
      chk("ready after rsp", 64'(o_ready[sel]), 64'd1);
   endtask

   task automatic chk_reset_outputs();
      chk("reset ready", 64'(o_ready[0]), 64'd1);
      chk("reset rsp_valid", 64'(o_rsp_valid[0]), 64'd0);
      chk("reset rsp_rdata", 64'(o_rsp_rdata[0]), 64'd0);
      chk("reset rsp_err", 64'(o_rsp_err[0]), 64'd0);
      chk("reset mem_req", 64'(o_mem_req[0]), 64'd0);
      chk("reset mem_we", 64'(o_mem_we[0]), 64'd0);
      chk("reset mem_be", 64'(o_mem_be[0]), 64'd0);
      chk("reset mem_addr", 64'(o_mem_addr[0]), 64'd0);
      chk("reset mem_wdata", 64'(o_mem_wdata[0]), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          s we f3      addr    wdata         mrdata        gd rd mq maddr   be
      //          mwdata        rdata         err    lat
      tbl.push_back(mk(0, 0, 3'b010, 12'h104, 32'h0, 32'hDEADBEEF, 0, 0, 1, 12'h104, 4'hF,
                       32'h0, 32'hDEADBEEF, 2'b00, 3));
      tbl.push_back(mk(0, 0, 3'b000, 12'h103, 32'h0, 32'h80112233, 0, 0, 1, 12'h100, 4'b1000,
                       32'h0, 32'hFFFFFF80, 2'b00, 3));
      tbl.push_back(mk(0, 0, 3'b100, 12'h103, 32'h0, 32'h80112233, 0, 0, 1, 12'h100, 4'b1000,
                       32'h0, 32'h00000080, 2'b00, 3));
      tbl.push_back(mk(0, 1, 3'b000, 12'h002, 32'hA5, 32'h12345678, 0, 0, 1, 12'h000, 4'b0100,
                       32'hA5A5A5A5, 32'h0, 2'b00, 3));
      tbl.push_back(mk(0, 0, 3'b001, 12'h001, 32'h0, 32'h0, 0, 0, 0, 12'h0, 4'h0,
                       32'h0, 32'h0, 2'b01, 1));
      tbl.push_back(mk(0, 0, 3'b011, 12'h008, 32'h0, 32'h0, 0, 0, 0, 12'h0, 4'h0,
                       32'h0, 32'h0, 2'b11, 1));
      tbl.push_back(mk(0, 0, 3'b001, 12'h102, 32'h0, 32'h80017FFF, 0, 0, 1, 12'h100, 4'b1100,
                       32'h0, 32'hFFFF8001, 2'b00, 3));
      tbl.push_back(mk(0, 0, 3'b101, 12'h102, 32'h0, 32'h80017FFF, 0, 0, 1, 12'h100, 4'b1100,
                       32'h0, 32'h00008001, 2'b00, 3));
      tbl.push_back(mk(0, 1, 3'b001, 12'h006, 32'h1234BEEF, 32'h0, 0, 1, 1, 12'h004, 4'b1100,
                       32'hBEEFBEEF, 32'h0, 2'b00, 4));
      tbl.push_back(mk(0, 1, 3'b010, 12'h0C8, 32'h11223344, 32'h0, 1, 0, 1, 12'h0C8, 4'hF,
                       32'h11223344, 32'h0, 2'b00, 4));
      tbl.push_back(mk(0, 1, 3'b100, 12'h000, 32'h0, 32'h0, 0, 0, 0, 12'h0, 4'h0,
                       32'h0, 32'h0, 2'b11, 1));
      tbl.push_back(mk(0, 0, 3'b111, 12'h000, 32'h0, 32'h0, 0, 0, 0, 12'h0, 4'h0,
                       32'h0, 32'h0, 2'b11, 1));
      tbl.push_back(mk(0, 0, 3'b110, 12'h000, 32'h0, 32'h0, 0, 0, 0, 12'h0, 4'h0,
                       32'h0, 32'h0, 2'b11, 1));
      tbl.push_back(mk(0, 1, 3'b010, 12'h0CA, 32'h0, 32'h0, 0, 0, 0, 12'h0, 4'h0,
                       32'h0, 32'h0, 2'b01, 1));
      // Grant held off 5 cycles: address/be/wdata checked every REQ cycle.
      tbl.push_back(mk(0, 0, 3'b010, 12'h200, 32'h0, 32'hCAFEF00D, 5, 2, 1, 12'h200, 4'hF,
                       32'h0, 32'hCAFEF00D, 2'b00, 10));
      tbl.push_back(mk(0, 0, 3'b000, 12'h0FF, 32'h0, 32'h7F000000, 0, 0, 1, 12'h0FC, 4'b1000,
                       32'h0, 32'h0000007F, 2'b00, 3));
      // Timeout instance: no grant -> err 10 on the 4th REQ cycle, response the cycle after.
      tbl.push_back(mk(1, 0, 3'b010, 12'h010, 32'h0, 32'h0, 99, 0, 1, 12'h010, 4'hF,
                       32'h0, 32'h0, 2'b10, 5));
      tbl.push_back(mk(1, 0, 3'b010, 12'h020, 32'h0, 32'h0BADCAFE, 0, 0, 1, 12'h020, 4'hF,
                       32'h0, 32'h0BADCAFE, 2'b00, 3));
      // Grant lands on the timeout cycle and wins.
      tbl.push_back(mk(1, 0, 3'b010, 12'h024, 32'h0, 32'h01020304, 3, 0, 1, 12'h024, 4'hF,
                       32'h0, 32'h01020304, 2'b00, 6));
      // rvalid lands on the timeout cycle and wins.
      tbl.push_back(mk(1, 0, 3'b010, 12'h028, 32'h0, 32'h0A0B0C0D, 0, 2, 1, 12'h028, 4'hF,
                       32'h0, 32'h0A0B0C0D, 2'b00, 5));

      // Reset state.
      repeat (3) @(negedge clk);
      #1 chk_reset_outputs();
      rstn = 1'b1;
      @(negedge clk);
      #1 chk_reset_outputs();

      // rvalid in IDLE is ignored.
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      chk("idle rvalid no rsp", 64'(o_rsp_valid[0]), 64'd0);
      chk("idle rvalid ready", 64'(o_ready[0]), 64'd1);

      foreach (tbl[i]) run_txn(tbl[i]);

      // Late rvalid after a WAIT timeout: one err pulse, then stall until rvalid.
      mem_rdata = 32'h55555555;
      drive_req(1'b1, 1'b0, 3'b010, 12'h030, 32'h0);
      for (int c = 1; c <= 14; c++) begin
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         #1;
         if (c == 1) begin
            chk("drain mem_req", 64'(o_mem_req[1]), 64'd1);
            mem_gnt = 1'b1;
         end
         if (c == 5) begin
            chk("drain rsp_valid pulse", 64'(o_rsp_valid[1]), 64'd1);
            chk("drain rsp_err", 64'(o_rsp_err[1]), 64'(2'b10));
            chk("drain rsp_rdata", 64'(o_rsp_rdata[1]), 64'd0);
         end else begin
            chk("drain rsp_valid quiet", 64'(o_rsp_valid[1]), 64'd0);
            chk("drain rsp_rdata quiet", 64'(o_rsp_rdata[1]), 64'd0);
         end
         chk("drain ready", 64'(o_ready[1]), (c <= 12) ? 64'd0 : 64'd1);
         if (c == 12) mem_rvalid = 1'b1;
         @(negedge clk);
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;

      // Reset while in WAIT, then a normal transaction.
      drive_req(1'b0, 1'b0, 3'b010, 12'h040, 32'h0);
      #1 chk("rst-seq mem_req", 64'(o_mem_req[0]), 64'd1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      #1;
      chk("rst-seq in wait", 64'(o_ready[0]), 64'd0);
      rstn = 1'b0;
      #1 chk_reset_outputs();
      @(negedge clk);
      rstn = 1'b1;
      run_txn(mk(0, 0, 3'b010, 12'h044, 32'h0, 32'h13579BDF, 0, 0, 1, 12'h044, 4'hF,
                 32'h0, 32'h13579BDF, 2'b00, 3));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
